aclk_display_ctrl: RTL
======================

# aclk_display_ctrl

Parametrised, registered display and alarm controller for the alarm clock, the next generation of the four-digit LCD driver. It selects per digit between key-entry, alarm and current time, converts each BCD digit to an LCD character code, and runs a sequential alarm-sounding state machine with stop, timeout and re-arm rules. It sits between the time/alarm registers plus key buffer and the LCD character interface.

## Interface
- NUM_DIGITS, 4: number of BCD digits, range 1–8; digit 0 is the least significant and occupies bits [3:0].
- SOUND_CYCLES, 1024: maximum number of clock cycles `sound_alarm` stays high per trigger, range 2–2^20.
- BLINK_HALF, 8: half-period of the edit-digit blink, in clock cycles, range ≥1. Used only with ALARM_BLINK_EN.
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- alarm_time  in  4*NUM_DIGITS  stored alarm time, BCD.
- current_time  in  4*NUM_DIGITS  running time, BCD.
- key_buf  in  4*NUM_DIGITS  digits being keyed in, BCD.
- show_new_time  in  1  display `key_buf`; highest priority.
- show_a  in  1  display `alarm_time`.
- alarm_enable  in  1  alarm armed when high.
- stop_alarm  in  1  level; silences a ringing alarm.
- edit_digit  in  clog2(NUM_DIGITS), min 1  index of the digit under edit.
- display  out  8*NUM_DIGITS  character codes; byte i is digit i.
- sound_alarm  out  1  alarm sounder drive.
- time_match  out  1  registered equality of `alarm_time` and `current_time`.

## Operation
- Source select per cycle:
  - `show_new_time`=1: `key_buf`.
  - Else `show_a`=1: `alarm_time`.
  - Else: `current_time`.
- Character code per digit:
  - Nibble 0–9: 8'h30 + nibble.
  - Nibble 10–15: 8'h2D (dash).
- Match: `match_c` is 1 when all digits of `alarm_time` equal those of `current_time` (full-width compare). `time_match` is `match_c` registered.
- Alarm FSM, encoded ARMED / RINGING / HOLD:
  - ARMED → RINGING when `alarm_enable` & `match_c`. The sound counter clears.
  - RINGING → HOLD when `stop_alarm`=1, or `alarm_enable`=0, or the counter reaches SOUND_CYCLES-1. Otherwise the counter increments.
  - HOLD → ARMED when `match_c`=0. HOLD prevents a retrigger within the same matching minute.
  - In any state, `alarm_enable`=0 forces HOLD.
  - Priority: stop/disable over timeout over count.
- `sound_alarm` = (state == RINGING), decoded from the state register.
- The counter is ceil(log2(SOUND_CYCLES)) bits wide and never wraps; it saturates by leaving RINGING.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `display`: all bytes 8'h30.
  - `sound_alarm` = 0, `time_match` = 0.
  - FSM state: HOLD.
  - Sound and blink counters: 0.
- Display latency is 1 cycle: inputs sampled at edge n appear on `display` after edge n.
- Alarm latency: `match_c` and `alarm_enable` both high at edge n → `sound_alarm`=1 after edge n.
- Stop latency: `stop_alarm` high at edge m → `sound_alarm`=0 after edge m.
- Timeout: `sound_alarm` is high for exactly SOUND_CYCLES cycles when not stopped.
- Boundary cases:
  - `stop_alarm` held high while entering from ARMED: RINGING lasts exactly 1 cycle, then HOLD.
  - Simultaneous `show_new_time` and `show_a`: key data is shown.
  - Reset mid-ring: `sound_alarm` drops asynchronously. After release the FSM starts in HOLD, so an alarm still matching does not retrigger until a mismatch is seen.
  - `current_time` changing while in HOLD: no effect until `match_c`=0.

## Configuration
- ALARM_BLINK_EN defined:
  - A free-running blink counter toggles a phase bit every BLINK_HALF cycles; the phase bit resets to 0 (visible).
  - While `show_new_time`=1 and the phase bit is 1, byte `edit_digit` of `display` shows 8'h20 (space).
  - `edit_digit` ≥ NUM_DIGITS blanks nothing.
- ALARM_BLINK_EN undefined:
  - No blink counter; `edit_digit` is ignored.
  - `display` is always the converted digit.

## Test plan
- Reset, then `current_time`=16'h1234 with no show inputs → `display`=32'h31_32_33_34 one cycle after the first edge; `sound_alarm`=0.
- `key_buf`=16'h0959, `alarm_time`=16'h0700, `show_new_time`=`show_a`=1 → `display`=32'h30_39_35_39. Then `show_new_time`=0 → 32'h30_37_30_30. Nibble 4'hA anywhere → that byte 8'h2D.
- `alarm_enable`=1, FSM brought to ARMED by a mismatch, `current_time` stepped to equal `alarm_time`=16'h0630 → `sound_alarm` rises on the next edge and stays high exactly SOUND_CYCLES cycles, then 0. No retrigger while still matching; a retrigger occurs after a mismatch followed by a rematch.
- While ringing, pulse `stop_alarm` for 1 cycle → `sound_alarm`=0 on the next edge and stays 0 during the match. Repeat with `alarm_enable` dropped instead → same result.
- Assert reset mid-ring → `sound_alarm` and `time_match` go to 0 immediately. Release with the match still present → no ring until a mismatch then a match.
- With ALARM_BLINK_EN, BLINK_HALF=8, `show_new_time`=1, `edit_digit`=2 → byte 2 alternates 8 cycles shown / 8 cycles 8'h20, other bytes steady. Without the macro → byte 2 is steady.

Source files
------------

// File: rtl/aclk_display_ctrl.sv
// Alarm clock display and alarm controller: per-digit source select, BCD to LCD
// character conversion, and the ARMED/RINGING/HOLD alarm sequencer.
// Optional edit-digit blink is built when ALARM_BLINK_EN is defined.
module aclk_display_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SOUND_CYCLES = 1024,
    parameter int BLINK_HALF   = 8
) (
    input  logic                                                 clock,
    input  logic                                                 reset,
    input  logic [4*NUM_DIGITS-1:0]                              alarm_time,
    input  logic [4*NUM_DIGITS-1:0]                              current_time,
    input  logic [4*NUM_DIGITS-1:0]                              key_buf,
    input  logic                                                 show_new_time,
    input  logic                                                 show_a,
    input  logic                                                 alarm_enable,
    input  logic                                                 stop_alarm,
    input  logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] edit_digit,
    output logic [8*NUM_DIGITS-1:0]                              display,
    output logic                                                 sound_alarm,
    output logic                                                 time_match
);

    localparam int CNT_W = $clog2(SOUND_CYCLES);

    localparam logic [1:0] ARMED   = 2'd0;
    localparam logic [1:0] RINGING = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    logic [4*NUM_DIGITS-1:0] src_digits;
    logic [8*NUM_DIGITS-1:0] display_next;
    logic                    match_c;
    logic [1:0]              state;
    logic [CNT_W-1:0]        sound_cnt;
    logic                    blink_on;

    function automatic logic [7:0] char_code(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return 8'h2D;
    endfunction

    always_comb begin
        if (show_new_time)
            src_digits = key_buf;
        else if (show_a)
            src_digits = alarm_time;
        else
            src_digits = current_time;
    end

    assign match_c = (alarm_time == current_time);

`ifdef ALARM_BLINK_EN
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    // Phase 0 is the visible half, so a freshly reset display never starts blanked.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blink_on = show_new_time & blink_phase;
`else
    localparam int unused_blink_half = BLINK_HALF;
    logic unused_edit;
    assign unused_edit = ^edit_digit;
    assign blink_on    = 1'b0;
`endif

    always_comb begin
        display_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (blink_on && (int'(edit_digit) == i))
                display_next[8*i +: 8] = 8'h20;
            else
                display_next[8*i +: 8] = char_code(src_digits[4*i +: 4]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            display    <= {NUM_DIGITS{8'h30}};
            time_match <= 1'b0;
        end else begin
            display    <= display_next;
            time_match <= match_c;
        end
    end

    // Starting in HOLD means a match already present at reset release cannot ring.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= HOLD;
            sound_cnt <= '0;
        end else if (!alarm_enable) begin
            state <= HOLD;
        end else begin
            case (state)
                ARMED: begin
                    if (match_c) begin
                        state     <= RINGING;
                        sound_cnt <= '0;
                    end
                end
                RINGING: begin
                    if (stop_alarm)
                        state <= HOLD;
                    else if (sound_cnt == CNT_W'(SOUND_CYCLES - 1))
                        state <= HOLD;
                    else
                        sound_cnt <= sound_cnt + 1'b1;
                end
                HOLD: begin
                    if (!match_c)
                        state <= ARMED;
                end
                default: state <= HOLD;
            endcase
        end
    end

    assign sound_alarm = (state == RINGING);

endmodule
